// File: rtl/display_pkg.sv
// Shared display constants: geometry, header layout, channel numbering and loader states.
// Used by pixel_row_loader, row_assembler and the HUB75 scan engine.
package display_pkg;

    localparam int COLOR_BITS     = 8;
    localparam int ROW_ADDR_BITS  = 6;
    localparam int ROW_ELEM       = 1 << ROW_ADDR_BITS;
    localparam int COL_ADDR_BITS  = 4;
    localparam int PARALLEL_SHIFT = 6;
    localparam int ROW_DAT_WIDTH  = ROW_ELEM * COLOR_BITS;
    localparam int TIMEOUT_CYCLES = 1024;

    localparam int HDR_SYNC_BIT = 7;
    localparam int HDR_CH_MSB   = 6;
    localparam int HDR_CH_LSB   = 4;
    localparam int HDR_ROW_MSB  = 3;
    localparam int CH_BITS      = HDR_CH_MSB - HDR_CH_LSB + 1;
    localparam int CNT_BITS     = ROW_ADDR_BITS + 1;

    localparam int CH_RED   = 0;
    localparam int CH_GREEN = 1;
    localparam int CH_BLUE  = 2;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        DATA  = 2'd1,
        WRITE = 2'd2
    } loader_state_e;

    // A header is usable only with sync set and a channel that maps to an existing RAM.
    function automatic logic hdr_ok(input logic [COLOR_BITS-1:0] hdr);
        return hdr[HDR_SYNC_BIT] &&
               (hdr[HDR_CH_MSB:HDR_CH_LSB] < CH_BITS'(PARALLEL_SHIFT));
    endfunction

endpackage

// File: rtl/pixel_row_loader_row_assembler.sv
// row_assembler: right-shifting row accumulator (new byte enters the top) plus byte counter.
// word_nxt exposes the shifted word so the loader can capture it on the final byte.
module row_assembler
    import display_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     shift,
    input  logic [COLOR_BITS-1:0]    din,
    output logic [ROW_DAT_WIDTH-1:0] word_nxt,
    output logic [CNT_BITS-1:0]      byte_cnt,
    output logic                     last
);

    logic [ROW_DAT_WIDTH-1:0] word_q, word_d;
    logic [CNT_BITS-1:0]      cnt_q, cnt_d;

    assign word_nxt = {din, word_q[ROW_DAT_WIDTH-1:COLOR_BITS]};
    assign byte_cnt = cnt_q;
    // Kept independent of shift so the loader FSM has no combinational loop through here.
    assign last     = (cnt_q == CNT_BITS'(ROW_ELEM - 1));

    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (shift) begin
            word_d = word_nxt;
            cnt_d  = cnt_q + CNT_BITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/pixel_row_loader.sv
// Packs a header + 64-byte stream packet into one 512-bit row write to a channel RAM.
// Optional inter-byte timeout: define PIXEL_ROW_LOADER_TIMEOUT_EN.
module pixel_row_loader
    import display_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [COLOR_BITS-1:0]     in_data,
    output logic [PARALLEL_SHIFT-1:0] ram_wen,
    output logic [COL_ADDR_BITS-1:0]  ram_waddr,
    output logic [ROW_DAT_WIDTH-1:0]  ram_wdata,
    output logic                      pkt_done,
    output logic                      pkt_err
);

    localparam logic [1:0] ST_HUNT  = 2'(HUNT);
    localparam logic [1:0] ST_DATA  = 2'(DATA);
    localparam logic [1:0] ST_WRITE = 2'(WRITE);

    logic [1:0]                state_q, state_d;
    logic [CH_BITS-1:0]        ch_q, ch_d;
    logic [COL_ADDR_BITS-1:0]  row_q, row_d;
    logic [PARALLEL_SHIFT-1:0] wen_q, wen_d;
    logic [COL_ADDR_BITS-1:0]  waddr_q, waddr_d;
    logic [ROW_DAT_WIDTH-1:0]  wdata_q, wdata_d;
    logic                      done_q, done_d;
    logic                      err_q, err_d;

`ifdef PIXEL_ROW_LOADER_TIMEOUT_EN
    localparam int GAP_BITS = $clog2(TIMEOUT_CYCLES + 1);
    logic [GAP_BITS-1:0] gap_q, gap_d;
`endif

    logic                     xfer;
    logic                     asm_clr, asm_shift, asm_last;
    logic [ROW_DAT_WIDTH-1:0] asm_word_nxt;
    logic [CNT_BITS-1:0]      byte_cnt;

    assign in_ready = (state_q != ST_WRITE);
    assign xfer     = in_valid && in_ready;

    row_assembler u_asm (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (asm_clr),
        .shift    (asm_shift),
        .din      (in_data),
        .word_nxt (asm_word_nxt),
        .byte_cnt (byte_cnt),
        .last     (asm_last)
    );

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        row_d     = row_q;
        wen_d     = '0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        asm_clr   = 1'b0;
        asm_shift = 1'b0;
`ifdef PIXEL_ROW_LOADER_TIMEOUT_EN
        gap_d     = gap_q;
`endif
        case (state_q)
            ST_HUNT: begin
                if (xfer) begin
                    if (hdr_ok(in_data)) begin
                        ch_d    = in_data[HDR_CH_MSB:HDR_CH_LSB];
                        row_d   = in_data[HDR_ROW_MSB:0];
                        asm_clr = 1'b1;
                        state_d = ST_DATA;
`ifdef PIXEL_ROW_LOADER_TIMEOUT_EN
                        gap_d   = '0;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    asm_shift = 1'b1;
                    // Output registers load on the final byte so the write lands in the WRITE cycle.
                    if (asm_last) begin
                        state_d = ST_WRITE;
                        wen_d   = PARALLEL_SHIFT'(1) << ch_q;
                        waddr_d = row_q;
                        wdata_d = asm_word_nxt;
                        done_d  = 1'b1;
                    end
`ifdef PIXEL_ROW_LOADER_TIMEOUT_EN
                    gap_d = '0;
                end else if (gap_q == GAP_BITS'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_HUNT;
                    err_d   = 1'b1;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q + GAP_BITS'(1);
`endif
                end
            end
            ST_WRITE: state_d = ST_HUNT;
            default:  state_d = ST_HUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_HUNT;
            ch_q    <= '0;
            row_q   <= '0;
            wen_q   <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef PIXEL_ROW_LOADER_TIMEOUT_EN
            gap_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            row_q   <= row_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef PIXEL_ROW_LOADER_TIMEOUT_EN
            gap_q   <= gap_d;
`endif
        end
    end

    assign ram_wen   = wen_q;
    assign ram_waddr = waddr_q;
    assign ram_wdata = wdata_q;
    assign pkt_done  = done_q;
    assign pkt_err   = err_q;

    // byte_cnt is observable for debug; the FSM only needs the last flag.
    logic unused_cnt;
    assign unused_cnt = ^byte_cnt;

endmodule

// File: tb/tb_pixel_row_loader.sv
// Directed + randomized bench for pixel_row_loader with a packet-level reference model.
// Build with PIXEL_ROW_LOADER_TIMEOUT_EN defined to exercise the gap timeout.
module tb_pixel_row_loader;
    import display_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_data;
    logic [5:0]   ram_wen;
    logic [3:0]   ram_waddr;
    logic [511:0] ram_wdata;
    logic         pkt_done;
    logic         pkt_err;

    pixel_row_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .ram_wen   (ram_wen),
        .ram_waddr (ram_waddr),
        .ram_wdata (ram_wdata),
        .pkt_done  (pkt_done),
        .pkt_err   (pkt_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           cyc;
        logic [5:0]   wen;
        logic [3:0]   addr;
        logic [511:0] data;
        logic         done;
    } wr_t;

    int   cyc = 0;
    int   err_cnt = 0;
    int   nrdy_cnt = 0;
    wr_t  wlog[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   last_acc = 0;
    logic [7:0] pb [64];

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ram_wen != 6'd0) wlog.push_back('{cyc, ram_wen, ram_waddr, ram_wdata, pkt_done});
            if (pkt_err) err_cnt <= err_cnt + 1;
            if (!in_ready) nrdy_cnt <= nrdy_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: pixel byte k sits at bits [8k+7:8k]; header rule from the packet format.
    function automatic logic [511:0] model_word();
        logic [511:0] w;
        for (int k = 0; k < 64; k++) w[8*k +: 8] = pb[k];
        return w;
    endfunction

    function automatic bit model_hdr_ok(input logic [7:0] h);
        return h[7] == 1'b1 && int'(h[6:4]) < 6;
    endfunction

    function automatic logic [7:0] rand_hdr();
        logic [2:0] ch;
        logic [3:0] row;
        ch  = 3'($urandom_range(0, 5));
        row = 4'($urandom_range(0, 15));
        return {1'b1, ch, row};
    endfunction

    task automatic send_byte(input logic [7:0] b, input int pct);
        int guard;
        bit acc;
        guard = 0;
        acc = 1'b0;
        while (!acc && guard < 400) begin
            @(negedge clk);
            in_data  = b;
            in_valid = ($urandom_range(0, 99) < pct);
            acc = in_valid && in_ready;
            guard++;
        end
        if (!acc) chk("accept_timeout", 512'(acc), 512'(1));
        last_acc = cyc + 1;
    endtask

    task automatic send_range(input int lo, input int hi, input int pct);
        for (int k = lo; k < hi; k++) send_byte(pb[k], pct);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        #1;
    endtask

    task automatic fill_rand();
        for (int k = 0; k < 64; k++) pb[k] = 8'($urandom);
    endtask

    // Pops one logged write and compares it against the model for header hdr.
    task automatic check_write(input string tag, input logic [7:0] hdr,
                               input logic [511:0] word, input int acc_cyc);
        wr_t w;
        chk({tag, ".present"}, 512'(wlog.size() > 0), 512'(1));
        if (wlog.size() > 0) begin
            w = wlog.pop_front();
            chk({tag, ".wen"},  512'(w.wen),  512'(6'd1 << hdr[6:4]));
            chk({tag, ".addr"}, 512'(w.addr), 512'(hdr[3:0]));
            chk({tag, ".data"}, w.data, word);
            chk({tag, ".done"}, 512'(w.done), 512'(1));
            chk({tag, ".lat"},  512'(w.cyc),  512'(acc_cyc));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".wen"},   512'(ram_wen),   512'(0));
        chk({tag, ".addr"},  512'(ram_waddr), 512'(0));
        chk({tag, ".data"},  ram_wdata,       512'(0));
        chk({tag, ".done"},  512'(pkt_done),  512'(0));
        chk({tag, ".err"},   512'(pkt_err),   512'(0));
        chk({tag, ".ready"}, 512'(in_ready),  512'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed running expected done");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]   h, h2;
        logic [511:0] w1, w2;
        int           a1, a2, e0, n0;
        wr_t          x;

        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        idle(2);

        // Single packet, ramp data
        for (int k = 0; k < 64; k++) pb[k] = 8'(k);
        n0 = nrdy_cnt; e0 = err_cnt;
        send_byte(8'h93, 100);
        send_range(0, 64, 100);
        idle(3);
        check_write("ramp", 8'h93, model_word(), last_acc);
        chk("ramp.byte0",   512'(ram_wdata[7:0]),     512'(8'h00));
        chk("ramp.byte63",  512'(ram_wdata[511:504]), 512'(8'h3F));
        chk("ramp.nready",  512'(nrdy_cnt - n0),      512'(1));
        chk("ramp.noerr",   512'(err_cnt - e0),       512'(0));
        chk("hold.addr",    512'(ram_waddr),          512'(3));
        chk("hold.data",    ram_wdata,                model_word());
        chk("hold.wen",     512'(ram_wen),            512'(0));

        // Back-to-back packets
        fill_rand();
        w1 = model_word();
        send_byte(8'hD0, 100);
        send_range(0, 64, 100);
        a1 = last_acc;
        fill_rand();
        w2 = model_word();
        send_byte(8'h8F, 100);
        send_range(0, 64, 100);
        a2 = last_acc;
        idle(3);
        chk("b2b.count", 512'(wlog.size()), 512'(2));
        if (wlog.size() == 2) begin
            x = wlog[0];
            chk("b2b.gap", 512'(wlog[1].cyc - x.cyc), 512'(66));
        end
        check_write("b2b0", 8'hD0, w1, a1);
        check_write("b2b1", 8'h8F, w2, a2);
        wlog.delete();

        // Rejected headers
        e0 = err_cnt;
        send_byte(8'h60, 100);
        send_byte(8'hE2, 100);
        idle(3);
        chk("badhdr.err",   512'(err_cnt - e0), 512'(2));
        chk("badhdr.nowr",  512'(wlog.size()),  512'(0));
        chk("badhdr.ready", 512'(in_ready),     512'(1));
        h = rand_hdr();
        fill_rand();
        send_byte(h, 100);
        send_range(0, 64, 100);
        idle(3);
        check_write("after_bad", h, model_word(), last_acc);

        // Throttled source, constant 0xA5 pixels
        for (int k = 0; k < 64; k++) pb[k] = 8'hA5;
        send_byte(8'hA7, 50);
        send_range(0, 64, 50);
        idle(3);
        chk("a5.count", 512'(wlog.size()), 512'(1));
        check_write("a5", 8'hA7, model_word(), last_acc);
        wlog.delete();

        // Reset mid-packet
        h = rand_hdr();
        fill_rand();
        send_byte(h, 100);
        send_range(0, 30, 100);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check_reset_outputs("midrst");
        rst_n = 1'b1;
        idle(3);
        chk("midrst.nowr", 512'(wlog.size()), 512'(0));
        h = rand_hdr();
        fill_rand();
        send_byte(h, 100);
        send_range(0, 64, 100);
        idle(3);
        check_write("post_rst", h, model_word(), last_acc);

        // Long stall inside a packet
        h = rand_hdr();
        fill_rand();
        e0 = err_cnt;
        send_byte(h, 100);
        send_range(0, 10, 100);
`ifdef PIXEL_ROW_LOADER_TIMEOUT_EN
        idle(1030);
        chk("stall.err",  512'(err_cnt - e0), 512'(1));
        chk("stall.nowr", 512'(wlog.size()),  512'(0));
        h2 = rand_hdr();
        fill_rand();
        send_byte(h2, 100);
        send_range(0, 64, 100);
        idle(3);
        check_write("stall.next", h2, model_word(), last_acc);
`else
        idle(1024);
        chk("stall.noerr", 512'(err_cnt - e0), 512'(0));
        send_range(10, 64, 100);
        idle(3);
        check_write("stall", h, model_word(), last_acc);
`endif

        // Random headers (some invalid) with random throttling
        for (int p = 0; p < 10; p++) begin
            h = 8'($urandom);
            if (p % 2 == 0) h[7] = 1'b1;
            e0 = err_cnt;
            if (model_hdr_ok(h)) begin
                fill_rand();
                send_byte(h, 100);
                send_range(0, 64, $urandom_range(30, 100));
                idle(3);
                check_write("rand", h, model_word(), last_acc);
                chk("rand.noerr", 512'(err_cnt - e0), 512'(0));
            end else begin
                send_byte(h, 100);
                idle(3);
                chk("rand.err",  512'(err_cnt - e0), 512'(1));
                chk("rand.nowr", 512'(wlog.size()),  512'(0));
            end
            wlog.delete();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
